data_memory_arbiter: RTL

//   Two-port round-robin arbiter and sequencer for the single-port DataMemory
//   (32-bit we/addr/wd/rd interface). Requester 0 is the CPU load/store path.

---
 rtl/data_memory_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter and sequencer that shares one single-port DataMemory between
// the CPU load/store path (port 0) and an auxiliary master (port 1).
module data_memory_arbiter #(
  parameter int unsigned RD_LAT     = 1,
  parameter logic [31:0] ADDR_LIMIT = 32'h0003_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wd0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic        err0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wd1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic        err1,
  output logic [31:0] rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [1:0] LatCnt = 2'(RD_LAT);

  state_e      r_state, w_state_d;
  logic        r_rr_last, w_rr_last_d;
  logic        r_we, w_we_d;
  logic [31:0] r_addr, w_addr_d;
  logic [31:0] r_wd, w_wd_d;
  logic        r_id, w_id_d;
  logic [1:0]  r_cnt, w_cnt_d;
  logic [1:0]  r_gnt, w_gnt_d;
  logic [1:0]  r_err, w_err_d;
  logic [1:0]  r_rvalid, w_rvalid_d;
  logic [31:0] r_rdata, w_rdata_d;
  logic        r_mem_we, w_mem_we_d;
  logic [31:0] r_mem_addr, w_mem_addr_d;
  logic [31:0] r_mem_wd, w_mem_wd_d;

  logic        w_win;
  logic        w_cmd_we;
  logic [31:0] w_cmd_addr;
  logic [31:0] w_cmd_wd;

  function automatic logic f_legal(input logic [31:0] a);
    return (a <= ADDR_LIMIT) && (a[1:0] == 2'b00);
  endfunction

  // On a tie the port that did not win the last tie goes first.
  assign w_win      = (req0 && req1) ? ~r_rr_last : req1;
  assign w_cmd_we   = w_win ? we1 : we0;
  assign w_cmd_addr = w_win ? addr1 : addr0;
  assign w_cmd_wd   = w_win ? wd1 : wd0;

  // Outputs are computed for the state being entered, then registered.
  always_comb begin
    w_state_d    = r_state;
    w_rr_last_d  = r_rr_last;
    w_we_d       = r_we;
    w_addr_d     = r_addr;
    w_wd_d       = r_wd;
    w_id_d       = r_id;
    w_cnt_d      = r_cnt;
    w_gnt_d      = 2'b00;
    w_err_d      = 2'b00;
    w_rvalid_d   = 2'b00;
    w_rdata_d    = r_rdata;
    w_mem_we_d   = 1'b0;
    w_mem_addr_d = 32'h0;
    w_mem_wd_d   = 32'h0;
    unique case (r_state)
      StIdle: begin
        if (req0 || req1) begin
          if (req0 && req1) w_rr_last_d = w_win;
          w_we_d         = w_cmd_we;
          w_addr_d       = w_cmd_addr;
          w_wd_d         = w_cmd_wd;
          w_id_d         = w_win;
          w_state_d      = StIssue;
          w_gnt_d[w_win] = 1'b1;
          if (!f_legal(w_cmd_addr)) begin
            w_err_d[w_win] = 1'b1;
          end else begin
            w_mem_we_d   = w_cmd_we;
            w_mem_addr_d = w_cmd_addr;
            if (w_cmd_we) w_mem_wd_d = w_cmd_wd;
          end
        end
      end
      StIssue: begin
        if (f_legal(r_addr) && !r_we) begin
          if (RD_LAT == 0) begin
            w_rdata_d        = mem_rd;
            w_rvalid_d[r_id] = 1'b1;
            w_state_d        = StResp;
          end else begin
            w_cnt_d      = 2'd1;
            w_mem_addr_d = r_addr;
            w_state_d    = StWait;
          end
        end else begin
          w_state_d = StIdle;
        end
      end
      StWait: begin
        if (r_cnt == LatCnt) begin
          w_rdata_d        = mem_rd;
          w_rvalid_d[r_id] = 1'b1;
          w_state_d        = StResp;
        end else begin
          w_cnt_d      = r_cnt + 2'd1;
          w_mem_addr_d = r_addr;
        end
      end
      StResp: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_rr_last  <= 1'b1;
      r_we       <= 1'b0;
      r_addr     <= 32'h0;
      r_wd       <= 32'h0;
      r_id       <= 1'b0;
      r_cnt      <= 2'd0;
      r_gnt      <= 2'b00;
      r_err      <= 2'b00;
      r_rvalid   <= 2'b00;
      r_rdata    <= 32'h0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= 32'h0;
      r_mem_wd   <= 32'h0;
    end else begin
      r_state    <= w_state_d;
      r_rr_last  <= w_rr_last_d;
      r_we       <= w_we_d;
      r_addr     <= w_addr_d;
      r_wd       <= w_wd_d;
      r_id       <= w_id_d;
      r_cnt      <= w_cnt_d;
      r_gnt      <= w_gnt_d;
      r_err      <= w_err_d;
      r_rvalid   <= w_rvalid_d;
      r_rdata    <= w_rdata_d;
      r_mem_we   <= w_mem_we_d;
      r_mem_addr <= w_mem_addr_d;
      r_mem_wd   <= w_mem_wd_d;
    end
  end

  assign gnt0     = r_gnt[0];
  assign gnt1     = r_gnt[1];
  assign err0     = r_err[0];
  assign err1     = r_err[1];
  assign rvalid0  = r_rvalid[0];
  assign rvalid1  = r_rvalid[1];
  assign rdata    = r_rdata;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_wd   = r_mem_wd;

endmodule
